sdram_arbiter: RTL and testbench

- Shares the single SDRAM command/response port between two requesters:
  - the GBA cartridge-bus engine (latency-critical);
  - the USB bridge (bulk code/video/sound/key transfers).
- Both requester ports use the same level-request / pulse-acknowledge protocol as the USB mux interface.
- One transaction is outstanding at a time. The arbiter latches the winner's command and drives the SDRAM controller, then routes write-accept or read-data back to the owner.

---
 rtl/sdram_arbiter.sv | 193 +++++++++++++++++++
 tb/tb_sdram_arbiter.sv | 390 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_arbiter.sv
// sdram_arbiter: shares one SDRAM command/response port between the
// GBA cartridge-bus engine and the USB bridge, one transaction at a time.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   gba_rd/gba_wr/gba_addr/...    GBA requester (level req, pulse ack)
//   usb_rd/usb_wr/usb_addr/...    USB requester (same protocol)
//   mem_cmd_* / mem_rsp_*         SDRAM controller command/response
//   busy                          arbiter is not idle
//
// Optional: define SDRAM_ARB_FAIR_EN to bound GBA runs to GBA_MAX_RUN
// consecutive grants while USB waits. Default is strict GBA priority.

module sdram_arbiter #(
    parameter int ADDR_W      = 26,
    parameter int DATA_W      = 32,
    parameter int GBA_MAX_RUN = 8
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              gba_rd,
    input  logic              gba_wr,
    input  logic [ADDR_W-1:0] gba_addr,
    input  logic [DATA_W-1:0] gba_wr_data,
    output logic              gba_wr_ready,
    output logic              gba_rd_valid,
    output logic [DATA_W-1:0] gba_rd_data,

    input  logic              usb_rd,
    input  logic              usb_wr,
    input  logic [ADDR_W-1:0] usb_addr,
    input  logic [DATA_W-1:0] usb_wr_data,
    output logic              usb_wr_ready,
    output logic              usb_rd_valid,
    output logic [DATA_W-1:0] usb_rd_data,

    output logic              mem_cmd_valid,
    input  logic              mem_cmd_ready,
    output logic              mem_cmd_we,
    output logic [ADDR_W-1:0] mem_cmd_addr,
    output logic [DATA_W-1:0] mem_cmd_wdata,
    input  logic              mem_rsp_valid,
    input  logic [DATA_W-1:0] mem_rsp_data,

    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CMD   = 2'd1,
        RWAIT = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_GBA  = 2'd1,
        OWN_USB  = 2'd2
    } owner_t;

    if (GBA_MAX_RUN < 1) begin : g_cfg_chk
        $error("sdram_arbiter: GBA_MAX_RUN must be >= 1");
    end

    state_t            state, state_nxt;
    owner_t            owner, owner_nxt;
    logic              we_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic [DATA_W-1:0] wdata_nxt;

    logic gba_req, usb_req;
    logic grant_gba, grant_usb;
    logic wr_ack, rd_ack;

    assign gba_req = gba_rd | gba_wr;
    assign usb_req = usb_rd | usb_wr;

`ifdef SDRAM_ARB_FAIR_EN
    localparam int RUN_W = $clog2(GBA_MAX_RUN + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(GBA_MAX_RUN);

    logic [RUN_W-1:0] run_cnt, run_cnt_nxt;
    logic             usb_turn;

    // USB takes the slot once GBA has used up its run.
    assign usb_turn  = usb_req && (!gba_req || run_cnt == RUN_MAX);
    assign grant_usb = usb_turn;
    assign grant_gba = gba_req && !usb_turn;

    always_comb begin
        run_cnt_nxt = run_cnt;
        if (state == IDLE) begin
            if (grant_usb) begin
                run_cnt_nxt = '0;
            end else if (grant_gba) begin
                if (!usb_req)
                    run_cnt_nxt = '0;
                else if (run_cnt != RUN_MAX)
                    run_cnt_nxt = run_cnt + RUN_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) run_cnt <= '0;
        else     run_cnt <= run_cnt_nxt;
    end
`else
    assign grant_gba = gba_req;
    assign grant_usb = usb_req && !gba_req;
`endif

    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        we_nxt    = mem_cmd_we;
        addr_nxt  = mem_cmd_addr;
        wdata_nxt = mem_cmd_wdata;
        unique case (state)
            IDLE: begin
                unique case (1'b1)
                    grant_gba: begin
                        state_nxt = CMD;
                        owner_nxt = OWN_GBA;
                        we_nxt    = gba_wr;
                        addr_nxt  = gba_addr;
                        wdata_nxt = gba_wr_data;
                    end
                    grant_usb: begin
                        state_nxt = CMD;
                        owner_nxt = OWN_USB;
                        we_nxt    = usb_wr;
                        addr_nxt  = usb_addr;
                        wdata_nxt = usb_wr_data;
                    end
                    default: ;
                endcase
            end
            CMD: begin
                if (mem_cmd_ready) begin
                    if (mem_cmd_we) begin
                        state_nxt = IDLE;
                        owner_nxt = OWN_NONE;
                    end else begin
                        state_nxt = RWAIT;
                    end
                end
            end
            RWAIT: begin
                if (mem_rsp_valid) begin
                    state_nxt = IDLE;
                    owner_nxt = OWN_NONE;
                end
            end
            default: begin
                state_nxt = IDLE;
                owner_nxt = OWN_NONE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            owner         <= OWN_NONE;
            mem_cmd_we    <= 1'b0;
            mem_cmd_addr  <= '0;
            mem_cmd_wdata <= '0;
        end else begin
            state         <= state_nxt;
            owner         <= owner_nxt;
            mem_cmd_we    <= we_nxt;
            mem_cmd_addr  <= addr_nxt;
            mem_cmd_wdata <= wdata_nxt;
        end
    end

    // Acks are combinational so the owner sees them in the
    // same cycle as the controller handshake.
    assign wr_ack = (state == CMD) && mem_cmd_ready && mem_cmd_we;
    assign rd_ack = (state == RWAIT) && mem_rsp_valid;

    assign mem_cmd_valid = (state == CMD);
    assign busy          = (state != IDLE);

    assign gba_wr_ready = wr_ack && (owner == OWN_GBA);
    assign usb_wr_ready = wr_ack && (owner == OWN_USB);
    assign gba_rd_valid = rd_ack && (owner == OWN_GBA);
    assign usb_rd_valid = rd_ack && (owner == OWN_USB);
    assign gba_rd_data  = gba_rd_valid ? mem_rsp_data : '0;
    assign usb_rd_data  = usb_rd_valid ? mem_rsp_data : '0;

endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter: directed vector table plus hand-written
// sequences for reset abort, long command stall and arbitration.

module tb_sdram_arbiter;

    localparam int AW = 26;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          gba_rd, gba_wr;
    logic [AW-1:0] gba_addr;
    logic [DW-1:0] gba_wr_data;
    logic          gba_wr_ready, gba_rd_valid;
    logic [DW-1:0] gba_rd_data;
    logic          usb_rd, usb_wr;
    logic [AW-1:0] usb_addr;
    logic [DW-1:0] usb_wr_data;
    logic          usb_wr_ready, usb_rd_valid;
    logic [DW-1:0] usb_rd_data;
    logic          mem_cmd_valid, mem_cmd_ready, mem_cmd_we;
    logic [AW-1:0] mem_cmd_addr;
    logic [DW-1:0] mem_cmd_wdata;
    logic          mem_rsp_valid;
    logic [DW-1:0] mem_rsp_data;
    logic          busy;

    always #5 clk = ~clk;

    sdram_arbiter #(
        .ADDR_W(AW),
        .DATA_W(DW),
        .GBA_MAX_RUN(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .gba_rd(gba_rd),
        .gba_wr(gba_wr),
        .gba_addr(gba_addr),
        .gba_wr_data(gba_wr_data),
        .gba_wr_ready(gba_wr_ready),
        .gba_rd_valid(gba_rd_valid),
        .gba_rd_data(gba_rd_data),
        .usb_rd(usb_rd),
        .usb_wr(usb_wr),
        .usb_addr(usb_addr),
        .usb_wr_data(usb_wr_data),
        .usb_wr_ready(usb_wr_ready),
        .usb_rd_valid(usb_rd_valid),
        .usb_rd_data(usb_rd_data),
        .mem_cmd_valid(mem_cmd_valid),
        .mem_cmd_ready(mem_cmd_ready),
        .mem_cmd_we(mem_cmd_we),
        .mem_cmd_addr(mem_cmd_addr),
        .mem_cmd_wdata(mem_cmd_wdata),
        .mem_rsp_valid(mem_rsp_valid),
        .mem_rsp_data(mem_rsp_data),
        .busy(busy)
    );

    typedef struct packed {
        logic          g_rd;
        logic          g_wr;
        logic [AW-1:0] g_addr;
        logic [DW-1:0] g_wd;
        logic          u_rd;
        logic          u_wr;
        logic [AW-1:0] u_addr;
        logic [DW-1:0] u_wd;
        logic          rdy;
        logic          rv;
        logic [DW-1:0] rdat;
    } vin_t;

    // chk selects whether the command fields are compared.
    typedef struct packed {
        logic          cv;
        logic          chk;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wd;
        logic          gwr;
        logic          grv;
        logic [DW-1:0] grd;
        logic          uwr;
        logic          urv;
        logic [DW-1:0] urd;
        logic          busy;
    } vex_t;

    typedef struct {
        vin_t  i;
        vex_t  e;
        string nm;
    } vec_t;

    int n_run  = 0;
    int n_fail = 0;
    vec_t tbl[$];

    function automatic vin_t iv(
        input logic          grd,
        input logic          gwr,
        input logic [AW-1:0] ga,
        input logic [DW-1:0] gd,
        input logic          urd,
        input logic          uwr,
        input logic [AW-1:0] ua,
        input logic [DW-1:0] ud,
        input logic          rdy,
        input logic          rv,
        input logic [DW-1:0] rdat
    );
        vin_t v;
        v.g_rd = grd;  v.g_wr = gwr;
        v.g_addr = ga; v.g_wd = gd;
        v.u_rd = urd;  v.u_wr = uwr;
        v.u_addr = ua; v.u_wd = ud;
        v.rdy = rdy;   v.rv = rv;
        v.rdat = rdat;
        return v;
    endfunction

    function automatic vex_t ex_idle();
        vex_t v = '0;
        return v;
    endfunction

    function automatic vex_t ex_rst();
        vex_t v = '0;
        v.chk = 1'b1;
        return v;
    endfunction

    function automatic vex_t ex_wait();
        vex_t v = '0;
        v.busy = 1'b1;
        return v;
    endfunction

    function automatic vex_t ex_cmd(
        input logic          we,
        input logic [AW-1:0] a,
        input logic [DW-1:0] d,
        input logic          gwr,
        input logic          uwr
    );
        vex_t v = '0;
        v.cv = 1'b1;  v.chk = 1'b1;
        v.we = we;    v.addr = a;
        v.wd = d;     v.busy = 1'b1;
        v.gwr = gwr;  v.uwr = uwr;
        return v;
    endfunction

    function automatic vex_t ex_rd(
        input logic          g,
        input logic [DW-1:0] d
    );
        vex_t v = '0;
        v.busy = 1'b1;
        if (g) begin
            v.grv = 1'b1; v.grd = d;
        end else begin
            v.urv = 1'b1; v.urd = d;
        end
        return v;
    endfunction

    task automatic add(input vin_t i, input vex_t e, input string nm);
        vec_t v;
        v.i = i; v.e = e; v.nm = nm;
        tbl.push_back(v);
    endtask

    task automatic drive(input vin_t v);
        gba_rd = v.g_rd;     gba_wr = v.g_wr;
        gba_addr = v.g_addr; gba_wr_data = v.g_wd;
        usb_rd = v.u_rd;     usb_wr = v.u_wr;
        usb_addr = v.u_addr; usb_wr_data = v.u_wd;
        mem_cmd_ready = v.rdy;
        mem_rsp_valid = v.rv;
        mem_rsp_data = v.rdat;
    endtask

    task automatic check(input vex_t e, input string nm);
        vex_t a;
        a.cv = mem_cmd_valid;   a.chk = e.chk;
        a.we = mem_cmd_we;      a.addr = mem_cmd_addr;
        a.wd = mem_cmd_wdata;   a.busy = busy;
        a.gwr = gba_wr_ready;   a.grv = gba_rd_valid;
        a.grd = gba_rd_data;    a.uwr = usb_wr_ready;
        a.urv = usb_rd_valid;   a.urd = usb_rd_data;
        if (!e.chk) begin
            a.we = e.we; a.addr = e.addr; a.wd = e.wd;
        end
        n_run++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got cv=%b we=%b addr=%h wd=%h gwr=%b grv=%b grd=%h uwr=%b urv=%b urd=%h busy=%b | want cv=%b we=%b addr=%h wd=%h gwr=%b grv=%b grd=%h uwr=%b urv=%b urd=%h busy=%b",
                nm, a.cv, a.we, a.addr, a.wd, a.gwr, a.grv, a.grd,
                a.uwr, a.urv, a.urd, a.busy,
                e.cv, e.we, e.addr, e.wd, e.gwr, e.grv, e.grd,
                e.uwr, e.urv, e.urd, e.busy);
        end
    endtask

    task automatic cmp_int(input string nm, input int got, input int want);
        n_run++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d want %0d", nm, got, want);
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        drive('0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    localparam logic [AW-1:0] A0 = '0;
    localparam logic [DW-1:0] D0 = '0;

    initial begin
        int g_cnt, u_cnt, seen, bad;
        int pat[$];

        rst = 1'b1;
        drive('0);

        // USB write, ready held high
        add(iv(0,0,A0,D0, 0,1,26'h1000000,32'hDEADBEEF, 1,0,D0),
            ex_idle(), "usbw_req");
        add(iv(0,0,A0,D0, 0,1,26'h1000000,32'hDEADBEEF, 1,0,D0),
            ex_cmd(1,26'h1000000,32'hDEADBEEF,0,1), "usbw_cmd");
        add(iv(0,0,A0,D0, 0,0,A0,D0, 1,0,D0),
            ex_idle(), "usbw_done");
        // GBA read, ready late, response late
        add(iv(1,0,26'h40,D0, 0,0,A0,D0, 0,0,D0),
            ex_idle(), "gbar_req");
        for (int k = 0; k < 3; k++)
            add(iv(1,0,26'h40,D0, 0,0,A0,D0, 0,0,D0),
                ex_cmd(0,26'h40,D0,0,0), "gbar_stall");
        add(iv(1,0,26'h40,D0, 0,0,A0,D0, 1,0,D0),
            ex_cmd(0,26'h40,D0,0,0), "gbar_acc");
        for (int k = 0; k < 4; k++)
            add(iv(1,0,26'h40,D0, 0,0,A0,D0, 0,0,D0),
                ex_wait(), "gbar_wait");
        add(iv(1,0,26'h40,D0, 0,0,A0,D0, 0,1,32'h12345678),
            ex_rd(1,32'h12345678), "gbar_rsp");
        add(iv(0,0,A0,D0, 0,0,A0,D0, 0,1,32'h77777777),
            ex_idle(), "idle_rsp_drop");
        // Simultaneous reads: GBA first, USB two cycles after ack
        add(iv(1,0,26'h100,D0, 1,0,26'h200,D0, 1,0,D0),
            ex_idle(), "both_req");
        add(iv(1,0,26'h100,D0, 1,0,26'h200,D0, 1,0,D0),
            ex_cmd(0,26'h100,D0,0,0), "both_gcmd");
        add(iv(1,0,26'h100,D0, 1,0,26'h200,D0, 1,1,32'hAAAA5555),
            ex_rd(1,32'hAAAA5555), "both_grsp");
        add(iv(0,0,A0,D0, 1,0,26'h200,D0, 1,0,D0),
            ex_idle(), "both_gap");
        add(iv(0,0,A0,D0, 1,0,26'h200,D0, 1,0,D0),
            ex_cmd(0,26'h200,D0,0,0), "both_ucmd");
        add(iv(0,0,A0,D0, 1,0,26'h200,D0, 1,1,32'h0BADF00D),
            ex_rd(0,32'h0BADF00D), "both_ursp");
        add(iv(0,0,A0,D0, 0,0,A0,D0, 1,0,D0),
            ex_idle(), "both_done");
        // rd+wr together is a write; top of address space
        add(iv(1,1,26'h3FFFFFC,32'hFFFFFFFF, 0,0,A0,D0, 1,0,D0),
            ex_idle(), "rdwr_req");
        add(iv(1,1,26'h3FFFFFC,32'hFFFFFFFF, 0,0,A0,D0, 1,0,D0),
            ex_cmd(1,26'h3FFFFFC,32'hFFFFFFFF,1,0), "rdwr_cmd");
        add(iv(0,0,A0,D0, 0,0,A0,D0, 1,0,D0),
            ex_idle(), "rdwr_done");
        // Owner drops request mid-transaction; ack still produced
        add(iv(0,0,A0,D0, 1,0,26'h8,D0, 0,0,D0),
            ex_idle(), "drop_req");
        add(iv(0,0,A0,D0, 0,0,26'h8,D0, 1,0,D0),
            ex_cmd(0,26'h8,D0,0,0), "drop_cmd");
        add(iv(0,0,A0,D0, 0,0,A0,D0, 0,1,32'h13579BDF),
            ex_rd(0,32'h13579BDF), "drop_rsp");
        add(iv(0,0,A0,D0, 0,0,A0,D0, 0,0,D0),
            ex_idle(), "drop_done");
        // Held write: re-granted two cycles after its ack
        add(iv(0,1,26'h44,32'h11111111, 0,0,A0,D0, 1,0,D0),
            ex_idle(), "b2b_req");
        add(iv(0,1,26'h44,32'h11111111, 0,0,A0,D0, 1,0,D0),
            ex_cmd(1,26'h44,32'h11111111,1,0), "b2b_ack1");
        add(iv(0,1,26'h44,32'h11111111, 0,0,A0,D0, 1,0,D0),
            ex_idle(), "b2b_gap");
        add(iv(0,1,26'h44,32'h11111111, 0,0,A0,D0, 1,0,D0),
            ex_cmd(1,26'h44,32'h11111111,1,0), "b2b_ack2");
        add(iv(0,0,A0,D0, 0,0,A0,D0, 1,0,D0),
            ex_idle(), "b2b_done");

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check(ex_rst(), "reset_state");
        @(posedge clk);
        #1;
        rst = 1'b0;

        foreach (tbl[i]) begin
            drive(tbl[i].i);
            @(negedge clk);
            check(tbl[i].e, tbl[i].nm);
            @(posedge clk);
            #1;
        end

        // Reset while waiting for read data
        drive(iv(1,0,26'h80,D0, 0,0,A0,D0, 1,0,D0));
        @(posedge clk); #1;
        @(posedge clk); #1;
        drive('0);
        rst = 1'b1;
        @(negedge clk);
        check(ex_wait(), "rst_in_rwait");
        @(posedge clk); #1;
        rst = 1'b0;
        drive(iv(0,0,A0,D0, 0,0,A0,D0, 0,1,32'h55AA55AA));
        @(negedge clk);
        check(ex_rst(), "rst_abort");
        @(posedge clk); #1;
        @(negedge clk);
        check(ex_rst(), "rst_rsp_drop");
        @(posedge clk); #1;
        drive('0);

        // Response in IDLE, then 20-cycle command stall
        drive(iv(0,0,A0,D0, 0,1,26'h2A0,32'hCAFEF00D, 0,1,32'h1));
        @(negedge clk);
        check(ex_idle(), "stall_req");
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            mem_rsp_valid = k[0];
            @(negedge clk);
            check(ex_cmd(1,26'h2A0,32'hCAFEF00D,0,0), "stall_hold");
        end
        @(posedge clk); #1;
        mem_cmd_ready = 1'b1;
        mem_rsp_valid = 1'b0;
        @(negedge clk);
        check(ex_cmd(1,26'h2A0,32'hCAFEF00D,0,1), "stall_acc");
        @(posedge clk); #1;
        drive('0);

        // Continuous competition for 100 write transactions
        do_reset();
        drive(iv(0,1,26'h10,32'h1, 0,1,26'h20,32'h2, 1,0,D0));
        g_cnt = 0;
        u_cnt = 0;
        seen  = 0;
        for (int c = 0; c < 400 && seen < 100; c++) begin
            @(negedge clk);
            if (gba_wr_ready) begin
                g_cnt++; seen++; pat.push_back(0);
            end
            if (usb_wr_ready) begin
                u_cnt++; seen++; pat.push_back(1);
            end
            @(posedge clk); #1;
        end
        drive('0);
        cmp_int("arb_txn_count", seen, 100);
`ifdef SDRAM_ARB_FAIR_EN
        bad = 0;
        foreach (pat[t])
            if (pat[t] != ((t % 9) == 8 ? 1 : 0)) bad++;
        cmp_int("fair_pattern_errs", bad, 0);
        cmp_int("fair_usb_grants", u_cnt, 11);
        cmp_int("fair_gba_grants", g_cnt, 89);
`else
        bad = 0;
        cmp_int("strict_usb_grants", u_cnt, 0);
        cmp_int("strict_gba_grants", g_cnt, 100);
        cmp_int("strict_pattern_errs", bad + pat.size(), 100);
`endif

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
